// File: rtl/memstream_rd_ctrl.sv
// Read sequencer for one ramb18_sdp weight memory. It streams START_ADDR..END_ADDR and wraps
// until stopped. Weights can be written at runtime, but only while the sequencer is idle.
module memstream_rd_ctrl #(
  parameter int unsigned DWIDTH     = 18,
  parameter int unsigned AWIDTH     = 10,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned END_ADDR   = 2**AWIDTH-1
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              start,
  input  logic              stop,
  output logic              busy,
  input  logic              cfg_wvalid,
  output logic              cfg_wready,
  input  logic [AWIDTH-1:0] cfg_waddr,
  input  logic [DWIDTH-1:0] cfg_wdata,
  output logic              mem_ena,
  output logic              mem_wea,
  output logic [AWIDTH-1:0] mem_addra,
  output logic [DWIDTH-1:0] mem_wdataa,
  output logic              mem_enb,
  output logic              mem_enqb,
  output logic [AWIDTH-1:0] mem_addrb,
  input  logic [DWIDTH-1:0] mem_rdqb,
  output logic [DWIDTH-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast
);

  localparam logic [AWIDTH-1:0] StartA = AWIDTH'(START_ADDR);
  localparam logic [AWIDTH-1:0] EndA   = AWIDTH'(END_ADDR);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] cnt_q, cnt_d;
  logic              v1_q, v1_d, v2_q, v2_d;
  logic              last1_q, last1_d, last2_q, last2_d;
  logic              adv, issue;

  always_comb begin
    // The whole read pipeline, RAM registers included, moves only on adv.
    adv     = ~v2_q | m_axis_tready;
    issue   = adv & (state_q == StRun);
    state_d = state_q;
    cnt_d   = cnt_q;
    v1_d    = v1_q;
    v2_d    = v2_q;
    last1_d = last1_q;
    last2_d = last2_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          cnt_d   = StartA;
        end
      end
      StRun:   if (stop) state_d = StDrain;
      StDrain: if (!v1_q && !v2_q) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (adv) begin
      v2_d    = v1_q;
      last2_d = last1_q;
      v1_d    = issue;
      last1_d = issue & (cnt_q == EndA);
    end

    if (issue) cnt_d = (cnt_q == EndA) ? StartA : cnt_q + 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= StIdle;
      cnt_q   <= StartA;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      last1_q <= 1'b0;
      last2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      last1_q <= last1_d;
      last2_q <= last2_d;
    end
  end

  assign busy          = (state_q != StIdle);
  assign cfg_wready    = (state_q == StIdle);
  assign mem_ena       = cfg_wvalid & cfg_wready;
  assign mem_wea       = mem_ena;
  assign mem_addra     = cfg_waddr;
  assign mem_wdataa    = cfg_wdata;
  // Held low during reset so the RAM read registers stay frozen.
  assign mem_enb       = adv & aresetn;
  assign mem_enqb      = adv & aresetn;
  assign mem_addrb     = cnt_q;
  assign m_axis_tdata  = mem_rdqb;
  assign m_axis_tvalid = v2_q;
  assign m_axis_tlast  = last2_q;

endmodule

// File: tb/tb_memstream_rd_ctrl.sv
// Self-checking bench: one 0..7 streamer and one single-word (5..5) streamer sharing stimulus,
// each attached to its own behavioural RAM, checked against a reference memory image.
module tb_memstream_rd_ctrl;

  logic        aclk = 1'b0;
  logic        aresetn, start, stop, cfg_wvalid, m_axis_tready;
  logic [9:0]  cfg_waddr;
  logic [17:0] cfg_wdata;

  logic        busy0, cfg_wready0, mem_ena0, mem_wea0, mem_enb0, mem_enqb0, tvalid0, tlast0;
  logic [9:0]  mem_addra0, mem_addrb0;
  logic [17:0] mem_wdataa0, mem_rdqb0, tdata0;
  logic        busy1, cfg_wready1, mem_ena1, mem_wea1, mem_enb1, mem_enqb1, tvalid1, tlast1;
  logic [9:0]  mem_addra1, mem_addrb1;
  logic [17:0] mem_wdataa1, mem_rdqb1, tdata1;

  logic [17:0] ram0 [0:1023];
  logic [17:0] ram1 [0:1023];
  logic [17:0] ram0_s1, ram1_s1;
  logic [17:0] ref_mem [0:1023];

  int n_chk = 0;
  int n_pass = 0;
  int hs0 = 0;
  int hs1 = 0;
  int exp_addr = 0;

  always #5 aclk = ~aclk;

  memstream_rd_ctrl #(.DWIDTH(18), .AWIDTH(10), .START_ADDR(0), .END_ADDR(7)) dut0 (
    .aclk(aclk), .aresetn(aresetn), .start(start), .stop(stop), .busy(busy0),
    .cfg_wvalid(cfg_wvalid), .cfg_wready(cfg_wready0), .cfg_waddr(cfg_waddr),
    .cfg_wdata(cfg_wdata), .mem_ena(mem_ena0), .mem_wea(mem_wea0), .mem_addra(mem_addra0),
    .mem_wdataa(mem_wdataa0), .mem_enb(mem_enb0), .mem_enqb(mem_enqb0),
    .mem_addrb(mem_addrb0), .mem_rdqb(mem_rdqb0), .m_axis_tdata(tdata0),
    .m_axis_tvalid(tvalid0), .m_axis_tready(m_axis_tready), .m_axis_tlast(tlast0)
  );

  memstream_rd_ctrl #(.DWIDTH(18), .AWIDTH(10), .START_ADDR(5), .END_ADDR(5)) dut1 (
    .aclk(aclk), .aresetn(aresetn), .start(start), .stop(stop), .busy(busy1),
    .cfg_wvalid(cfg_wvalid), .cfg_wready(cfg_wready1), .cfg_waddr(cfg_waddr),
    .cfg_wdata(cfg_wdata), .mem_ena(mem_ena1), .mem_wea(mem_wea1), .mem_addra(mem_addra1),
    .mem_wdataa(mem_wdataa1), .mem_enb(mem_enb1), .mem_enqb(mem_enqb1),
    .mem_addrb(mem_addrb1), .mem_rdqb(mem_rdqb1), .m_axis_tdata(tdata1),
    .m_axis_tvalid(tvalid1), .m_axis_tready(m_axis_tready), .m_axis_tlast(tlast1)
  );

  // Behavioural ramb18_sdp: port A write, port B two-stage registered read.
  always @(posedge aclk) begin
    if (mem_ena0 && mem_wea0) ram0[mem_addra0] <= mem_wdataa0;
    if (mem_enb0) ram0_s1 <= ram0[mem_addrb0];
    if (mem_enqb0) mem_rdqb0 <= ram0_s1;
    if (mem_ena1 && mem_wea1) ram1[mem_addra1] <= mem_wdataa1;
    if (mem_enb1) ram1_s1 <= ram1[mem_addrb1];
    if (mem_enqb1) mem_rdqb1 <= ram1_s1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard: the stream must be ref_mem[START..END] repeated from the start of each run.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (tvalid0) begin
        chk("s0_tdata", tdata0, ref_mem[exp_addr]);
        chk("s0_tlast", tlast0, exp_addr == 7);
        if (m_axis_tready) begin
          hs0++;
          exp_addr = (exp_addr == 7) ? 0 : exp_addr + 1;
        end
      end
      if (tvalid1) begin
        chk("s1_tdata", tdata1, ref_mem[5]);
        chk("s1_tlast", tlast1, 1);
        if (m_axis_tready) hs1++;
      end
      chk("s1_addrb", mem_addrb1, 5);
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    cfg_wvalid = 1'b1;
    cfg_waddr  = 10'(a);
    cfg_wdata  = 18'(d);
    @(negedge aclk);
    chk("wr_ena", mem_ena0, 1);
    chk("wr_wea", mem_wea0, 1);
    chk("wr_addra", mem_addra0, a);
    chk("wr_wdataa", mem_wdataa0, d);
    tick();
    ref_mem[a] = 18'(d);
    cfg_wvalid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && (busy0 || busy1); i++) tick();
    chk("idle0_reached", busy0, 0);
    chk("idle1_reached", busy1, 0);
  endtask

  typedef struct {
    logic        tvalid;
    logic [17:0] tdata;
    logic        tlast;
  } vec_t;

  vec_t t1 [14];
  int   hsb;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 14; k++) begin
      t1[k].tvalid = (k + 1) >= 3;
      t1[k].tdata  = 18'(12'h100 + ((k + 1 + 8 - 3) % 8));
      t1[k].tlast  = ((k + 1 + 8 - 3) % 8) == 7;
    end
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;

    aresetn = 1'b0; start = 1'b0; stop = 1'b0; cfg_wvalid = 1'b0;
    cfg_waddr = '0; cfg_wdata = '0; m_axis_tready = 1'b1;

    // T0/T1: reset values, load 0x100+i, then stream with tready held high.
    @(negedge aclk);
    chk("rst_busy", busy0, 0);
    chk("rst_tvalid", tvalid0, 0);
    chk("rst_tlast", tlast0, 0);
    chk("rst_enb", mem_enb0, 0);
    chk("rst_enqb", mem_enqb0, 0);
    chk("rst_wready", cfg_wready0, 1);
    chk("rst_wready1", cfg_wready1, 1);
    chk("rst_ena", mem_ena0, 0);
    chk("rst_addrb", mem_addrb0, 0);
    tick();
    aresetn = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) wr(i, 'h100 + i);

    start = 1'b1;
    exp_addr = 0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(negedge aclk);
      chk("t1_busy", busy0, 1);
      chk("t1_tvalid", tvalid0, t1[k].tvalid);
      if (t1[k].tvalid) begin
        chk("t1_tdata", tdata0, t1[k].tdata);
        chk("t1_tlast", tlast0, t1[k].tlast);
      end
      tick();
    end

    // T2/T4a: random backpressure with write attempts that must be refused.
    hsb = hs0;
    for (int c = 0; c < 200; c++) begin
      m_axis_tready = ($urandom_range(0, 1) != 0);
      cfg_wvalid    = ($urandom_range(0, 1) != 0);
      cfg_waddr     = 10'($urandom_range(0, 7));
      cfg_wdata     = 18'($urandom);
      @(negedge aclk);
      chk("run_wready", cfg_wready0, 0);
      chk("run_ena", mem_ena0, 0);
      chk("run_wea", mem_wea0, 0);
      tick();
    end
    cfg_wvalid = 1'b0;
    chk("t2_progress", (hs0 - hsb) > 40, 1);

    // T3: stop under backpressure with two words in flight.
    m_axis_tready = 1'b0;
    tick(); tick(); tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      chk("t3_hold_busy", busy0, 1);
      chk("t3_hold_tvalid", tvalid0, 1);
      tick();
    end
    hsb = hs0;
    m_axis_tready = 1'b1;
    @(negedge aclk); chk("t3_a_tvalid", tvalid0, 1); tick();
    @(negedge aclk); chk("t3_b_tvalid", tvalid0, 1); tick();
    @(negedge aclk); chk("t3_c_tvalid", tvalid0, 0); chk("t3_c_busy", busy0, 1); tick();
    @(negedge aclk); chk("t3_d_busy", busy0, 0); chk("t3_d_wready", cfg_wready0, 1);
    chk("t3_words", hs0 - hsb, 2);
    tick();

    // T4: idle write to mem[3], then a write to mem[0] in the same cycle as start.
    wr(3, 'h2AA);
    cfg_wvalid = 1'b1; cfg_waddr = 10'd0; cfg_wdata = 18'h155;
    start = 1'b1;
    exp_addr = 0;
    @(negedge aclk);
    chk("t4_start_ena", mem_ena0, 1);
    tick();
    ref_mem[0] = 18'h155;
    start = 1'b0; cfg_wvalid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge aclk);
      if (k == 3) chk("t4_word0", tdata0, 'h155);
      if (k == 6) chk("t4_word3", tdata0, 'h2AA);
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    hsb = hs0;
    wait_idle(20);
    chk("t4_stop_words", hs0 - hsb, 2);

    // T5: asynchronous reset between edges mid-stream.
    start = 1'b1;
    exp_addr = 0;
    tick();
    start = 1'b0;
    for (int c = 0; c < 30; c++) begin
      m_axis_tready = ($urandom_range(0, 1) != 0);
      tick();
    end
    m_axis_tready = 1'b1;
    tick();
    @(posedge aclk);
    #3 aresetn = 1'b0;
    #1;
    chk("t5_tvalid", tvalid0, 0);
    chk("t5_busy", busy0, 0);
    chk("t5_tvalid1", tvalid1, 0);
    chk("t5_busy1", busy1, 0);
    tick(); tick();
    aresetn = 1'b1;
    @(negedge aclk);
    chk("t5_rel_tvalid", tvalid0, 0);
    chk("t5_rel_addrb", mem_addrb0, 0);
    tick();
    start = 1'b1;
    exp_addr = 0;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge aclk);
      if (k == 3) chk("t5_restart_word", tdata0, ref_mem[0]);
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_idle(20);

    // T6: start and stop together in idle must enter RUN; dut1 streams mem[5] only.
    hsb = hs1;
    start = 1'b1; stop = 1'b1;
    exp_addr = 0;
    tick();
    start = 1'b0; stop = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge aclk);
      chk("t6_busy0", busy0, 1);
      chk("t6_busy1", busy1, 1);
      tick();
    end
    chk("t6_words1", (hs1 - hsb) >= 5, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_idle(20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
